// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: shared state encoding, width helper and defaults for the delay scheduler
package delay_sched_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int DEF_BITS = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational request picker, round-robin from a pointer or fixed priority under DELAY_SCHED_FIXED_PRIO_EN
module rr_arbiter
  import delay_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifndef DELAY_SCHED_FIXED_PRIO_EN
  input  logic [PW-1:0]      i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx
);
  // scan from the highest search offset down so the nearest asserted requester wins
  always_comb begin
    o_idx = '0;
`ifdef DELAY_SCHED_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req[k]) o_idx = PW'(k);
`else
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) o_idx = PW'((int'(i_ptr) + k) % NUM_REQ);
`endif
    o_gnt = |i_req ? NUM_REQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/delay_sched_ctrl.sv
// delay_sched_ctrl: time-shares one tick counter among requesters; fixed priority under DELAY_SCHED_FIXED_PRIO_EN
module delay_sched_ctrl
  import delay_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BITS    = DEF_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*BITS-1:0] req_ticks,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic                    cnt_clear,
  output logic                    cnt_enable,
  input  logic [BITS-1:0]         cnt_value
);
  localparam int PW = clog2(NUM_REQ);
  logic [1:0]         r_state, w_next;
  logic [BITS-1:0]    r_target;
  logic [PW-1:0]      r_idx, w_arb_idx;
  logic [NUM_REQ-1:0] r_grant, r_done, w_grant, w_done, w_arb_gnt;
  logic               r_busy, r_clear, r_enable, w_busy, w_clear, w_enable, w_cancel;
  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = r_busy;
  assign cnt_clear  = r_clear;
  assign cnt_enable = r_enable;
`ifndef DELAY_SCHED_FIXED_PRIO_EN
  logic [PW-1:0] r_ptr;
  // move the search start past whoever just finished or cancelled
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ptr <= '0;
    else if (r_state == DONE || w_cancel) r_ptr <= (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.i_req(req), .i_ptr(r_ptr), .o_gnt(w_arb_gnt), .o_idx(w_arb_idx));
`else
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.i_req(req), .o_gnt(w_arb_gnt), .o_idx(w_arb_idx));
`endif
  // state, registered outputs and the winner's target captured at grant
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_clear  <= 1'b0;
      r_enable <= 1'b0;
      r_target <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_next;
      r_grant  <= w_grant;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_clear  <= w_clear;
      r_enable <= w_enable;
      if (r_state == IDLE && |req) begin
        r_target <= req_ticks[int'(w_arb_idx)*BITS +: BITS];
        r_idx    <= w_arb_idx;
      end
    end
  // next state; a dropped request wins over expiry in the same cycle
  always_comb begin
    w_cancel = (r_state == LOAD || r_state == RUN) && !req[r_idx];
    case (r_state)
      IDLE:    w_next = |req ? LOAD : IDLE;
      LOAD:    w_next = w_cancel ? IDLE : (r_target == '0) ? DONE : RUN;
      RUN:     w_next = w_cancel ? IDLE : (cnt_value == r_target - 1'b1) ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  // outputs follow the upcoming state so they land registered with it
  always_comb begin
    w_grant  = (w_next == IDLE) ? '0 : (r_state == IDLE) ? w_arb_gnt : r_grant;
    w_done   = (w_next == DONE) ? r_grant : '0;
    w_busy   = w_next != IDLE;
    w_clear  = w_next == LOAD;
    w_enable = w_next == RUN;
  end
endmodule

// File: tb/tb_delay_sched_ctrl.sv
// tb_delay_sched_ctrl: scoreboard bench pairing the scheduler with a behavioural tick counter
module tb_delay_sched_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_ticks;
  logic [3:0]  grant, done;
  logic        busy, cnt_clear, cnt_enable;
  logic [15:0] cnt_value;
  int cyc = 0, npass = 0, ntotal = 0, c0, r;
  typedef struct {int idx; int cyc;} exp_t;
  exp_t q[$];
  exp_t e_mon;

  delay_sched_ctrl #(.NUM_REQ(4), .BITS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ticks(req_ticks), .grant(grant), .done(done),
    .busy(busy), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stands in for GUCounter: async reset from ~reset, sync user_reset from cnt_clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_value <= '0;
    else if (cnt_clear) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // every done pulse must match the next scoreboard entry in index and cycle
  always @(negedge clk)
    if (reset && |done) begin
      if (q.size() == 0) check("done_unexp", {28'd0, done}, 32'd0);
      else begin
        e_mon = q.pop_front();
        check("done_idx", {28'd0, done}, 32'd1 << e_mon.idx);
        check("done_cyc", cyc, e_mon.cyc);
      end
    end

  initial begin
    reset = 1'b0; req = '0; req_ticks = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_clear", cnt_clear, 0);
    check("rst_en", cnt_enable, 0);
    reset = 1'b1;
    @(negedge clk);
    // single request, 5 ticks
    c0 = cyc; req_ticks[16 +: 16] = 16'd5; req = 4'b0010; q.push_back('{1, c0 + 7});
    @(negedge clk);
    check("t1_grant", grant, 4'b0010);
    check("t1_clear", cnt_clear, 1);
    check("t1_en_load", cnt_enable, 0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      check("t1_en", cnt_enable, 1);
    end
    @(negedge clk);
    check("t1_en_off", cnt_enable, 0);
    check("t1_grant_held", grant, 4'b0010);
    req = '0;
    @(negedge clk);
    check("t1_busy", busy, 0);
    check("t1_grant_clr", grant, 0);
    // zero ticks
    c0 = cyc; req_ticks[0 +: 16] = 16'd0; req = 4'b0001; q.push_back('{0, c0 + 2});
    @(negedge clk);
    check("t2_grant", grant, 4'b0001);
    check("t2_clear", cnt_clear, 1);
    check("t2_en1", cnt_enable, 0);
    @(negedge clk);
    check("t2_en2", cnt_enable, 0);
    req = '0;
    @(negedge clk);
    check("t2_busy", busy, 0);
    // round-robin over all four from a fresh pointer
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) req_ticks[i*16 +: 16] = 16'd2;
    c0 = cyc; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef DELAY_SCHED_FIXED_PRIO_EN
      q.push_back('{0, c0 + 4 + 5*i});
`else
      q.push_back('{i % 4, c0 + 4 + 5*i});
`endif
    end
    @(negedge clk);
    check("t3_grant", grant, 4'b0001);
    repeat (23) @(negedge clk);
    req = '0;
    @(negedge clk);
    check("t3_busy", busy, 0);
    // cancel mid-RUN with a pending requester behind
    c0 = cyc; req_ticks[32 +: 16] = 16'd10; req_ticks[48 +: 16] = 16'd1; req = 4'b1100;
    q.push_back('{3, c0 + 9});
    @(negedge clk);
    check("t4_grant", grant, 4'b0100);
    repeat (4) @(negedge clk);
    check("t4_cnt", cnt_value, 3);
    req = 4'b1000;
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_grant_clr", grant, 0);
    @(negedge clk);
    check("t4_grant3", grant, 4'b1000);
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    // cancel collides with expiry
    c0 = cyc; req_ticks[0 +: 16] = 16'd3; req = 4'b0001;
    @(negedge clk);
    check("t5_grant", grant, 4'b0001);
    repeat (3) @(negedge clk);
    check("t5_cnt", cnt_value, 2);
    req = '0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    // async reset mid-RUN
    req_ticks[0 +: 16] = 16'd6; req_ticks[16 +: 16] = 16'd8; req = 4'b0011;
    @(negedge clk);
`ifdef DELAY_SCHED_FIXED_PRIO_EN
    check("t6_grant", grant, 4'b0001);
`else
    check("t6_grant", grant, 4'b0010);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_clear", cnt_clear, 0);
    check("t6_rst_en", cnt_enable, 0);
    @(negedge clk);
    reset = 1'b1; r = cyc; q.push_back('{0, r + 8});
    @(negedge clk);
    check("t6_regrant", grant, 4'b0001);
    repeat (7) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    check("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/delay_sched_ctrl.md
Name: delay_sched_ctrl

Overview:
- Controller that time-shares one external GUCounter-style tick counter between NUM_REQ requesters. Each requester needs a programmable delay, for example SPI CS setup/hold or accelerometer power-up waits.
- Arbitrates requests, clears and enables the shared counter, compares its count against the granted requester's tick target, and pulses a per-requester done.
- Sits between the accelerometer driver FSMs and a single shared counter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BITS, 16, counter and tick-target width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester delay request; held high until done, or dropped to cancel.
- req_ticks  in  NUM_REQ*BITS  packed tick targets; slice i belongs to req[i]; sampled at grant.
- grant  out  NUM_REQ  one-hot; the requester currently owning the counter.
- done  out  NUM_REQ  one-cycle pulse to the served requester when its delay expires.
- busy  out  1  high whenever state != IDLE.
- cnt_clear  out  1  drives the counter's user_reset.
- cnt_enable  out  1  drives the counter's enable.
- cnt_value  in  BITS  counter's registered count output.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - grant, done, busy, cnt_clear and cnt_enable go to 0.
  - Target register and RR pointer go to 0.
  - Reset mid-operation abandons the delay with no done pulse.
- All outputs are registered.
- IDLE:
  - If any req bit is set, the arbiter picks winner g.
  - Latch target = req_ticks[g].
  - Set grant=onehot(g), go to LOAD.
- LOAD, one cycle:
  - cnt_clear=1, cnt_enable=0.
  - If target==0, go to DONE. Otherwise go to RUN.
- RUN:
  - cnt_enable=1.
  - When cnt_value == target-1, go to DONE. RUN lasts exactly target cycles.
- DONE, one cycle:
  - done[g]=1 and grant still held; cnt_enable=0.
  - Advance RR pointer to g+1 mod NUM_REQ; return to IDLE, where grant clears.
- Latency: req rises before edge 0 → grant/LOAD at cycle 1 → RUN at cycles 2..T+1 → done at cycle T+2.
- Cancel:
  - If req[g] drops during LOAD or RUN, go to IDLE next cycle with no done.
  - RR pointer still advances.
  - Cancel beats expiry when both occur in the same cycle.
- Round-robin arbitration:
  - Search starts at the pointer and wraps at NUM_REQ-1 → 0.
  - The pointer moves only on DONE or cancel.
- A requester holding req after done is re-arbitrated in IDLE behind the other pending requesters.
- req_ticks changes after LOAD are ignored.
- target = all-ones is legal and gives 2^BITS-1 RUN cycles. The counter never wraps because RUN exits first.

Optional Feature:
- Macro DELAY_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest asserted index always wins and the RR pointer is not implemented.
- Undefined (default): round-robin as above.

Decomposition:
- Package delay_sched_pkg holds:
  - State encoding localparams: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
  - clog2 function for pointer width.
  - Default BITS constant.
- Sub-module rr_arbiter #(NUM_REQ):
  - Inputs: req and pointer. Output: one-hot grant plus encoded index.
  - Purely combinational.
  - Contains the DELAY_SCHED_FIXED_PRIO_EN branch.
- Bench pairs the block with a real counter instance:
  - GUCounter #(BITS=16, SYNCH_RESET=0).
  - Its reset_in = {~reset, cnt_clear}.

Test Plan:
- Single request: req[1]=1, ticks[1]=5 → grant=0010 at cycle 1, cnt_enable high at cycles 2–6, done[1] pulse at cycle 7, busy low at cycle 8.
- Zero ticks: req[0]=1, ticks[0]=0 → LOAD then DONE; done[0] at cycle 2; cnt_enable never asserted.
- Round-robin: req=1111 held, all ticks=2 → grant order 0,1,2,3,0; each done spaced 5 cycles apart. With DELAY_SCHED_FIXED_PRIO_EN, req 0 is served repeatedly.
- Cancel: req[2] with ticks=10 dropped at RUN cycle 4 → IDLE next cycle; no done; pending req[3] granted the following cycle.
- Cancel/expiry collision: ticks=3, req dropped in the same cycle cnt_value==2 → no done pulse.
- Async reset mid-RUN: reset=0 for 1 cycle → all outputs 0 immediately, before any clock edge. After release with req still high, arbitration restarts from index 0.
